// File: rtl/gb_wave_ram_arbiter_if.sv
// Wave RAM arbiter bus: channel fetch port and CPU access port.
// The requester side drives the master modport; the arbiter owns slave.
interface gb_wave_ram_arbiter_if;
   logic       ch_on;
   logic       ch_fetch_req;
   logic [3:0] ch_addr;
   logic       ch_fetch_ack;
   logic [7:0] ch_data;
   logic       cpu_req;
   logic       cpu_we;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       cpu_stall;

   modport master (
      output ch_on,
      output ch_fetch_req,
      output ch_addr,
      input  ch_fetch_ack,
      input  ch_data,
      output cpu_req,
      output cpu_we,
      output cpu_addr,
      output cpu_wdata,
      input  cpu_ack,
      input  cpu_rdata,
      input  cpu_stall
   );

   modport slave (
      input  ch_on,
      input  ch_fetch_req,
      input  ch_addr,
      output ch_fetch_ack,
      output ch_data,
      input  cpu_req,
      input  cpu_we,
      input  cpu_addr,
      input  cpu_wdata,
      output cpu_ack,
      output cpu_rdata,
      output cpu_stall
   );
endinterface

// File: rtl/gb_wave_ram_arbiter.sv
// Channel 3 wave RAM (16 x 8) with a single port shared between the
// wave channel sample fetch (priority) and the CPU bus.
module gb_wave_ram_arbiter (
   input  logic                 clk,
   input  logic                 reset,
   gb_wave_ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CH,
      CPU
   } state_t;

   state_t     state;
   state_t     nxt;
   logic [7:0] mem [16];
   logic [3:0] ch_addr_q;
   logic [7:0] ch_data_q;
   logic [7:0] cpu_rdata_q;
   logic       stall_q;
   logic       cpu_ack_w;
   logic [3:0] ea;

   assign cpu_ack_w = (state == CPU);

   // Channel has absolute priority; a CPU request is ignored while acked.
   always_comb begin
      nxt = IDLE;
      if (bus.ch_fetch_req) begin
         nxt = CH;
      end else if (bus.cpu_req && !cpu_ack_w) begin
         nxt = CPU;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // While playing, the CPU only reaches the byte the channel last fetched.
   assign ea = bus.ch_on ? ch_addr_q : bus.cpu_addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] <= 8'h00;
         end
         ch_addr_q   <= 4'h0;
         ch_data_q   <= 8'h00;
         cpu_rdata_q <= 8'h00;
         stall_q     <= 1'b0;
      end else begin
         stall_q <= bus.cpu_req && !cpu_ack_w && bus.ch_fetch_req;
         if (nxt == CH) begin
            ch_data_q <= mem[bus.ch_addr];
            ch_addr_q <= bus.ch_addr;
         end
         if (nxt == CPU) begin
            if (bus.cpu_we) begin
               mem[ea] <= bus.cpu_wdata;
            end else begin
               cpu_rdata_q <= mem[ea];
            end
         end
      end
   end

   assign bus.ch_fetch_ack = (state == CH);
   assign bus.ch_data      = ch_data_q;
   assign bus.cpu_ack      = cpu_ack_w;
   assign bus.cpu_rdata    = cpu_rdata_q;
   assign bus.cpu_stall    = stall_q;

endmodule

// File: tb/tb_gb_wave_ram_arbiter.sv
// Bench for gb_wave_ram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level wave RAM model.
module tb_gb_wave_ram_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;

   gb_wave_ram_arbiter_if bus ();

   gb_wave_ram_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic [7:0] ref_mem [16];
   logic [3:0] ref_chq;
   logic [7:0] ref_rdata;
   logic       ch_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      ref_chq   = 4'h0;
      ref_rdata = 8'h00;
   endfunction

   function automatic logic [7:0] model_fetch(input logic [3:0] a);
      ref_chq = a;
      return ref_mem[a];
   endfunction

   function automatic logic [7:0] model_cpu(input logic on, input logic we,
                                             input logic [3:0] a,
                                             input logic [7:0] d);
      logic [3:0] e;
      e = on ? ref_chq : a;
      if (we) ref_mem[e] = d;
      else ref_rdata = ref_mem[e];
      return ref_rdata;
   endfunction

   task automatic cpu_access(input logic we, input logic [3:0] a,
                             input logic [7:0] d, output logic [7:0] rd,
                             output int lat);
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_req   = 1'b1;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (bus.cpu_ack) begin
            lat = i;
            break;
         end
      end
      rd = bus.cpu_rdata;
      bus.cpu_req = 1'b0;
      tick();
   endtask

   task automatic ch_fetch(input logic [3:0] a, output logic [7:0] data,
                           output int lat, output logic ack_after);
      bus.ch_addr      = a;
      bus.ch_fetch_req = 1'b1;
      tick();
      bus.ch_fetch_req = 1'b0;
      lat  = bus.ch_fetch_ack ? 1 : -1;
      data = bus.ch_data;
      tick();
      ack_after = bus.ch_fetch_ack;
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      int lat;
      logic [20:0] outs;
      bus.ch_on        = 1'b1;
      bus.ch_fetch_req = 1'b1;
      bus.cpu_req      = 1'b1;
      bus.cpu_we       = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.ch_addr   = 4'($urandom_range(0, 15));
         bus.cpu_addr  = 4'($urandom_range(0, 15));
         bus.cpu_wdata = 8'($urandom_range(1, 255));
         tick();
         outs = {bus.ch_fetch_ack, bus.ch_data, bus.cpu_ack,
                 bus.cpu_rdata, bus.cpu_stall, 2'b00};
         checks++;
         if (outs !== 21'h0)
            $display("FAIL reset_outs cycle %0d got %h want 0", c, outs);
         else passed++;
      end
      bus.ch_on        = 1'b0;
      bus.ch_fetch_req = 1'b0;
      bus.cpu_req      = 1'b0;
      bus.cpu_we       = 1'b0;
      reset = 1'b1;
      model_reset();
      tick();
      cpu_access(1'b0, 4'd5, 8'h00, rd, lat);
      checks++;
      if (lat !== 1) $display("FAIL reset_rd_lat got %0d want 1", lat);
      else passed++;
      checks++;
      if (rd !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd);
      else passed++;
   endtask

   task automatic test_write_fetch();
      logic [7:0] rd;
      logic [7:0] d;
      int lat;
      logic aa;
      bus.ch_on = 1'b0;
      void'(model_cpu(1'b0, 1'b1, 4'd3, 8'hA7));
      cpu_access(1'b1, 4'd3, 8'hA7, rd, lat);
      checks++;
      if (lat !== 1) $display("FAIL wr_lat got %0d want 1", lat);
      else passed++;
      void'(model_fetch(4'd3));
      ch_fetch(4'd3, d, lat, aa);
      checks++;
      if (lat !== 1 || d !== 8'hA7)
         $display("FAIL fetch3 got lat %0d data %h want 1 a7", lat, d);
      else passed++;
      checks++;
      if (aa !== 1'b0) $display("FAIL fetch_ack_len got %b want 0", aa);
      else passed++;
   endtask

   task automatic test_collision();
      logic [7:0] rd;
      int lat;
      bus.ch_on = 1'b0;
      void'(model_cpu(1'b0, 1'b1, 4'd1, 8'h5E));
      cpu_access(1'b1, 4'd1, 8'h5E, rd, lat);
      void'(model_cpu(1'b0, 1'b1, 4'd0, 8'h21));
      cpu_access(1'b1, 4'd0, 8'h21, rd, lat);
      void'(model_fetch(4'd0));
      void'(model_cpu(1'b0, 1'b0, 4'd1, 8'h00));
      bus.ch_addr      = 4'd0;
      bus.ch_fetch_req = 1'b1;
      bus.cpu_addr     = 4'd1;
      bus.cpu_we       = 1'b0;
      bus.cpu_req      = 1'b1;
      tick();
      bus.ch_fetch_req = 1'b0;
      checks++;
      if ({bus.ch_fetch_ack, bus.cpu_stall, bus.cpu_ack} !== 3'b110 ||
          bus.ch_data !== 8'h21)
         $display("FAIL coll_c1 got ack/stall/cack %b%b%b data %h want 110 21",
                  bus.ch_fetch_ack, bus.cpu_stall, bus.cpu_ack, bus.ch_data);
      else passed++;
      tick();
      checks++;
      if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h5E ||
          bus.cpu_stall !== 1'b0)
         $display("FAIL coll_c2 got ack %b stall %b data %h want 1 0 5e",
                  bus.cpu_ack, bus.cpu_stall, bus.cpu_rdata);
      else passed++;
      bus.cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_redirect();
      logic [7:0] rd;
      logic [7:0] d;
      int lat;
      logic aa;
      bus.ch_on = 1'b0;
      void'(model_cpu(1'b0, 1'b1, 4'd2, 8'h11));
      cpu_access(1'b1, 4'd2, 8'h11, rd, lat);
      void'(model_cpu(1'b0, 1'b1, 4'd9, 8'h3C));
      cpu_access(1'b1, 4'd9, 8'h3C, rd, lat);
      void'(model_fetch(4'd9));
      ch_fetch(4'd9, d, lat, aa);
      checks++;
      if (d !== 8'h3C) $display("FAIL redir_fetch got %h want 3c", d);
      else passed++;
      bus.ch_on = 1'b1;
      void'(model_cpu(1'b1, 1'b0, 4'd2, 8'h00));
      cpu_access(1'b0, 4'd2, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h3C || lat !== 1)
         $display("FAIL redir_rd got %h lat %0d want 3c 1", rd, lat);
      else passed++;
      void'(model_cpu(1'b1, 1'b1, 4'd2, 8'h55));
      cpu_access(1'b1, 4'd2, 8'h55, rd, lat);
      checks++;
      if (rd !== 8'h3C) $display("FAIL redir_wr_rdata got %h want 3c", rd);
      else passed++;
      bus.ch_on = 1'b0;
      void'(model_cpu(1'b0, 1'b0, 4'd9, 8'h00));
      cpu_access(1'b0, 4'd9, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h55) $display("FAIL redir_mem9 got %h want 55", rd);
      else passed++;
      void'(model_cpu(1'b0, 1'b0, 4'd2, 8'h00));
      cpu_access(1'b0, 4'd2, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h11) $display("FAIL redir_mem2 got %h want 11", rd);
      else passed++;
   endtask

   task automatic test_max_rate();
      logic [7:0] rd;
      int lat;
      bus.ch_on = 1'b0;
      for (int a = 0; a < 16; a++) begin
         logic [7:0] d;
         d = 8'($urandom);
         void'(model_cpu(1'b0, 1'b1, 4'(a), d));
         cpu_access(1'b1, 4'(a), d, rd, lat);
      end
      ch_done = 1'b0;
      fork
         begin
            for (int a = 0; a < 16; a++) begin
               logic [7:0] exp;
               exp = model_fetch(4'(a));
               bus.ch_addr      = 4'(a);
               bus.ch_fetch_req = 1'b1;
               tick();
               bus.ch_fetch_req = 1'b0;
               checks++;
               if (bus.ch_fetch_ack !== 1'b1 || bus.ch_data !== exp)
                  $display("FAIL mr_fetch a%0d got ack %b data %h want 1 %h",
                           a, bus.ch_fetch_ack, bus.ch_data, exp);
               else passed++;
               if (a == 0) begin
                  checks++;
                  if (bus.cpu_stall !== 1'b1)
                     $display("FAIL mr_stall got %b want 1", bus.cpu_stall);
                  else passed++;
               end
               tick();
            end
            ch_done = 1'b1;
         end
         begin
            int first;
            int l;
            logic [3:0] ca;
            logic [7:0] exp;
            first = 1;
            bus.cpu_we  = 1'b0;
            bus.cpu_req = 1'b1;
            while (!ch_done) begin
               ca = 4'($urandom_range(0, 15));
               bus.cpu_addr = ca;
               exp = model_cpu(1'b0, 1'b0, ca, 8'h00);
               l = -1;
               for (int i = 1; i <= 5; i++) begin
                  tick();
                  if (bus.cpu_ack) begin
                     l = i;
                     break;
                  end
               end
               // After an ack the next edge ignores the held request.
               if (!first && l > 0) l = l - 1;
               first = 0;
               checks++;
               if (l < 1 || l > 2 || bus.cpu_rdata !== exp)
                  $display("FAIL mr_cpu a%0d got lat %0d data %h want <=2 %h",
                           ca, l, bus.cpu_rdata, exp);
               else passed++;
               if (l < 0) break;
            end
            bus.cpu_req = 1'b0;
         end
      join
      tick();
      tick();
   endtask

   task automatic test_random();
      logic [7:0] rd;
      logic [7:0] d;
      logic [7:0] ef;
      logic [7:0] ec;
      logic [3:0] a;
      logic [3:0] ca;
      logic on;
      logic we;
      logic aa;
      int lat;
      int op;
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 3);
         on = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 15));
         ca = 4'($urandom_range(0, 15));
         d  = 8'($urandom);
         bus.ch_on = on;
         if (op == 0) begin
            ef = model_fetch(ca);
            ch_fetch(ca, rd, lat, aa);
            checks++;
            if (lat !== 1 || rd !== ef)
               $display("FAIL rnd%0d fetch got lat %0d data %h want 1 %h",
                        n, lat, rd, ef);
            else passed++;
         end else if (op != 3) begin
            ec = model_cpu(on, we, a, d);
            cpu_access(we, a, d, rd, lat);
            checks++;
            if (lat !== 1 || rd !== ec)
               $display("FAIL rnd%0d cpu got lat %0d data %h want 1 %h",
                        n, lat, rd, ec);
            else passed++;
         end else begin
            ef = model_fetch(ca);
            ec = model_cpu(on, we, a, d);
            bus.ch_addr      = ca;
            bus.ch_fetch_req = 1'b1;
            bus.cpu_addr     = a;
            bus.cpu_we       = we;
            bus.cpu_wdata    = d;
            bus.cpu_req      = 1'b1;
            tick();
            bus.ch_fetch_req = 1'b0;
            checks++;
            if (bus.ch_fetch_ack !== 1'b1 || bus.ch_data !== ef ||
                bus.cpu_stall !== 1'b1 || bus.cpu_ack !== 1'b0)
               $display("FAIL rnd%0d coll1 got ack %b data %h stall %b want 1 %h 1",
                        n, bus.ch_fetch_ack, bus.ch_data, bus.cpu_stall, ef);
            else passed++;
            tick();
            checks++;
            if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== ec)
               $display("FAIL rnd%0d coll2 got ack %b data %h want 1 %h",
                        n, bus.cpu_ack, bus.cpu_rdata, ec);
            else passed++;
            bus.cpu_req = 1'b0;
            tick();
         end
      end
      bus.ch_on = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [7:0] rd;
      logic [7:0] d;
      int lat;
      logic aa;
      bus.ch_on = 1'b0;
      void'(model_cpu(1'b0, 1'b1, 4'd4, 8'hE4));
      cpu_access(1'b1, 4'd4, 8'hE4, rd, lat);
      void'(model_cpu(1'b0, 1'b0, 4'd4, 8'h00));
      cpu_access(1'b0, 4'd4, 8'h00, rd, lat);
      void'(model_fetch(4'd4));
      ch_fetch(4'd4, d, lat, aa);
      checks++;
      if (rd !== 8'hE4 || d !== 8'hE4)
         $display("FAIL ar_pre got %h %h want e4 e4", rd, d);
      else passed++;
      bus.ch_addr      = 4'd6;
      bus.ch_fetch_req = 1'b1;
      bus.cpu_addr     = 4'd7;
      bus.cpu_we       = 1'b1;
      bus.cpu_wdata    = 8'h99;
      bus.cpu_req      = 1'b1;
      tick();
      bus.ch_fetch_req = 1'b0;
      checks++;
      if (bus.cpu_stall !== 1'b1 || bus.ch_fetch_ack !== 1'b1)
         $display("FAIL ar_pending got stall %b ack %b want 1 1",
                  bus.cpu_stall, bus.ch_fetch_ack);
      else passed++;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.ch_fetch_ack, bus.cpu_ack, bus.cpu_stall} !== 3'b000 ||
          bus.ch_data !== 8'h00 || bus.cpu_rdata !== 8'h00)
         $display("FAIL ar_clear got %b%b%b %h %h want 000 00 00",
                  bus.ch_fetch_ack, bus.cpu_ack, bus.cpu_stall,
                  bus.ch_data, bus.cpu_rdata);
      else passed++;
      bus.cpu_req = 1'b0;
      model_reset();
      tick();
      reset = 1'b1;
      tick();
      cpu_access(1'b0, 4'd7, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h00 || lat !== 1)
         $display("FAIL ar_rd7 got %h lat %0d want 00 1", rd, lat);
      else passed++;
      cpu_access(1'b0, 4'd4, 8'h00, rd, lat);
      checks++;
      if (rd !== 8'h00) $display("FAIL ar_rd4 got %h want 00", rd);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bus.ch_on        = 1'b0;
      bus.ch_fetch_req = 1'b0;
      bus.ch_addr      = 4'h0;
      bus.cpu_req      = 1'b0;
      bus.cpu_we       = 1'b0;
      bus.cpu_addr     = 4'h0;
      bus.cpu_wdata    = 8'h00;
      ch_done          = 1'b0;
      model_reset();
      test_reset();
      test_write_fetch();
      test_collision();
      test_redirect();
      test_max_rate();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
